// File: rtl/gl_cmd_writer_pkg.sv
// GL command definitions shared by the command writer and the fetch stage:
// opcode constants and the opcode-to-length rule both ends step by.
package gl_defines;

   localparam logic [7:0] OP_VERTEX     = 8'h03;
   localparam logic [7:0] OP_COLOR      = 8'h04;
   localparam logic [7:0] OP_MULTMATRIX = 8'h11;
   localparam logic [7:0] OP_LOADMATRIX = 8'h13;
   localparam logic [7:0] OP_ROTATE     = 8'h16;
   localparam logic [7:0] OP_SCALE      = 8'h17;
   localparam logic [7:0] OP_TRANSLATE  = 8'h18;
   localparam logic [7:0] OP_VIEWPORT   = 8'h19;
   localparam logic [7:0] OP_FRUSTUM    = 8'h1A;

   localparam int CMD_LEN_W = 5;
   typedef logic [CMD_LEN_W-1:0] cmd_len_t;

   typedef enum logic [1:0] {
      ST_HDR,
      ST_BODY,
      ST_DROP
   } wr_state_e;

   // Length in words including the header; unknown opcodes are header-only.
   function automatic cmd_len_t gl_cmd_len(input logic [7:0] op);
      cmd_len_t len;
      case (op)
         OP_VERTEX, OP_COLOR:                 len = cmd_len_t'(4);
         OP_MULTMATRIX, OP_LOADMATRIX,
         OP_ROTATE, OP_SCALE, OP_TRANSLATE:   len = cmd_len_t'(17);
         OP_VIEWPORT:                         len = cmd_len_t'(5);
         OP_FRUSTUM:                          len = cmd_len_t'(7);
         default:                             len = cmd_len_t'(1);
      endcase
      return len;
   endfunction

endpackage

// File: rtl/gl_cmd_writer_if.sv
// Host word stream into the GL command writer: valid/ready handshake.
interface gl_cmd_writer_if #(
   parameter int WIDTH = 32
);
   logic             cmd_valid;
   logic [WIDTH-1:0] cmd_word;
   logic             cmd_ready;

   modport master (output cmd_valid, output cmd_word, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_word, output cmd_ready);
endinterface

// File: rtl/gl_cmd_writer_len_lut.sv
// Combinational opcode -> command length lookup, shared with the fetch stage.
module gl_cmd_len_lut
   import gl_defines::*;
(
   input  logic [7:0] opcode,
   output cmd_len_t   len
);
   assign len = gl_cmd_len(opcode);
endmodule

// File: rtl/gl_cmd_writer.sv
// Packs host GL commands into the BRAM command buffer and publishes a commit pointer.
// Define GL_CMDW_CSUM_EN to build the running XOR checksum of committed words.
module gl_cmd_writer
   import gl_defines::*;
#(
   parameter int TEXT_START = 0,
   parameter int WIDTH      = 32,
   parameter int BUF_BYTES  = 4096
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               hold,
   gl_cmd_writer_if.slave     cmd,
   output logic               bram_we,
   output logic [WIDTH-1:0]   bram_addr,
   output logic [WIDTH-1:0]   bram_wdata,
   output logic [WIDTH-1:0]   commit_addr,
   output logic [15:0]        cmd_count,
   output logic               overflow,
   output logic [WIDTH-1:0]   cmd_csum
);

   localparam logic [WIDTH-1:0] START_ADDR = WIDTH'(TEXT_START);
   localparam logic [WIDTH:0]   END_ADDR   = (WIDTH+1)'(TEXT_START) + (WIDTH+1)'(BUF_BYTES);

   wr_state_e        state_q, state_d;
   logic [WIDTH-1:0] wr_addr_q, wr_addr_d;
   cmd_len_t         rem_q, rem_d;
   logic [WIDTH-1:0] commit_addr_q, commit_addr_d;
   logic [15:0]      cmd_count_q, cmd_count_d;
   logic             overflow_q, overflow_d;
   logic             we_q, we_d;
   logic [WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic             pend_q, pend_d;
   logic [WIDTH-1:0] pend_addr_q, pend_addr_d;
`ifdef GL_CMDW_CSUM_EN
   logic [WIDTH-1:0] csum_q, csum_d;
   logic [WIDTH-1:0] part_q, part_d;
   logic [WIDTH-1:0] pend_csum_q, pend_csum_d;
`endif

   logic             accept;
   logic             fits;
   logic             commit_now;
   cmd_len_t         hdr_len;
   logic [WIDTH-1:0] wr_addr_inc;

   gl_cmd_len_lut u_len_lut (
      .opcode (cmd.cmd_word[7:0]),
      .len    (hdr_len)
   );

   assign cmd.cmd_ready = reset & ~hold;
   assign accept        = cmd.cmd_valid & cmd.cmd_ready;
   assign wr_addr_inc   = wr_addr_q + WIDTH'(4);
   // Widened by one bit so a command ending exactly at the top of the address space cannot wrap.
   assign fits          = ({1'b0, wr_addr_q} + (WIDTH+1)'({hdr_len, 2'b00})) <= END_ADDR;

   always_comb begin
      state_d       = state_q;
      wr_addr_d     = wr_addr_q;
      rem_d         = rem_q;
      commit_addr_d = commit_addr_q;
      cmd_count_d   = cmd_count_q;
      overflow_d    = overflow_q;
      we_d          = 1'b0;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      pend_d        = 1'b0;
      pend_addr_d   = pend_addr_q;
      commit_now    = 1'b0;
`ifdef GL_CMDW_CSUM_EN
      csum_d        = csum_q;
      part_d        = part_q;
      pend_csum_d   = pend_csum_q;
`endif

      // The commit lands one cycle after the last word's write strobe.
      if (pend_q) begin
         commit_addr_d = pend_addr_q;
         cmd_count_d   = cmd_count_q + 16'd1;
`ifdef GL_CMDW_CSUM_EN
         csum_d        = csum_q ^ pend_csum_q;
`endif
      end

      if (accept) begin
         case (state_q)
            ST_HDR: begin
               rem_d = hdr_len - cmd_len_t'(1);
               if (fits) begin
                  we_d      = 1'b1;
                  addr_d    = wr_addr_q;
                  wdata_d   = cmd.cmd_word;
                  wr_addr_d = wr_addr_inc;
`ifdef GL_CMDW_CSUM_EN
                  part_d    = cmd.cmd_word;
`endif
                  if (hdr_len == cmd_len_t'(1)) commit_now = 1'b1;
                  else                          state_d    = ST_BODY;
               end else begin
                  overflow_d = 1'b1;
                  if (hdr_len != cmd_len_t'(1)) state_d = ST_DROP;
               end
            end
            ST_BODY: begin
               we_d      = 1'b1;
               addr_d    = wr_addr_q;
               wdata_d   = cmd.cmd_word;
               wr_addr_d = wr_addr_inc;
               rem_d     = rem_q - cmd_len_t'(1);
`ifdef GL_CMDW_CSUM_EN
               part_d    = part_q ^ cmd.cmd_word;
`endif
               if (rem_q == cmd_len_t'(1)) begin
                  commit_now = 1'b1;
                  state_d    = ST_HDR;
               end
            end
            ST_DROP: begin
               rem_d = rem_q - cmd_len_t'(1);
               if (rem_q == cmd_len_t'(1)) state_d = ST_HDR;
            end
            default: state_d = ST_HDR;
         endcase
      end

      if (commit_now) begin
         pend_d      = 1'b1;
         pend_addr_d = wr_addr_inc;
`ifdef GL_CMDW_CSUM_EN
         pend_csum_d = part_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= ST_HDR;
         wr_addr_q     <= START_ADDR;
         rem_q         <= '0;
         commit_addr_q <= START_ADDR;
         cmd_count_q   <= '0;
         overflow_q    <= 1'b0;
         we_q          <= 1'b0;
         addr_q        <= START_ADDR;
         wdata_q       <= '0;
         pend_q        <= 1'b0;
         pend_addr_q   <= START_ADDR;
`ifdef GL_CMDW_CSUM_EN
         csum_q        <= '0;
         part_q        <= '0;
         pend_csum_q   <= '0;
`endif
      end else begin
         state_q       <= state_d;
         wr_addr_q     <= wr_addr_d;
         rem_q         <= rem_d;
         commit_addr_q <= commit_addr_d;
         cmd_count_q   <= cmd_count_d;
         overflow_q    <= overflow_d;
         we_q          <= we_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         pend_q        <= pend_d;
         pend_addr_q   <= pend_addr_d;
`ifdef GL_CMDW_CSUM_EN
         csum_q        <= csum_d;
         part_q        <= part_d;
         pend_csum_q   <= pend_csum_d;
`endif
      end
   end

   assign bram_we     = we_q;
   assign bram_addr   = addr_q;
   assign bram_wdata  = wdata_q;
   assign commit_addr = commit_addr_q;
   assign cmd_count   = cmd_count_q;
   assign overflow    = overflow_q;
`ifdef GL_CMDW_CSUM_EN
   assign cmd_csum    = csum_q;
`else
   assign cmd_csum    = '0;
`endif

endmodule
